// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches a 4-digit 7-segment frame once per scan and
// time-multiplexes it onto a common-anode display, with an all-off blanking
// window at the start of every digit slot to suppress ghosting.
// Optional build macro SEG7_SCAN_DIM_EN adds a brightness input that PWMs the
// anode during the drive part of each slot.
module seg7_scan_driver #(
   parameter int unsigned DIVISOR      = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] frame,
`ifdef SEG7_SCAN_DIM_EN
   input  logic [3:0]  brightness,
`endif
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_sync
);

   localparam int unsigned TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIVISOR - 1);

   typedef enum logic {SLOT_BLANK, SLOT_DRIVE} slot_e;

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]    dig_q, dig_d;
   logic [27:0]   frame_q, frame_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_sync_q, frame_sync_d;
   logic          tick_wrap;
   logic          latch_now;
   slot_e         slot_state;
   logic [6:0]    digit_pat;
`ifdef SEG7_SCAN_DIM_EN
   logic [3:0]    pwm_cnt_q, pwm_cnt_d;
`endif

   // Slot timing, digit advance and end-of-scan frame capture
   always_comb begin
      tick_wrap    = (tick_cnt_q == TICK_LAST);
      tick_cnt_d   = tick_wrap ? '0 : tick_cnt_q + 1'b1;
      dig_d        = tick_wrap ? dig_q + 2'd1 : dig_q;
      latch_now    = tick_wrap && (dig_q == 2'd3);
      frame_d      = latch_now ? frame : frame_q;
      frame_sync_d = latch_now;
      dp_d         = 1'b1;
`ifdef SEG7_SCAN_DIM_EN
      pwm_cnt_d    = pwm_cnt_q + 4'd1;
`endif
   end

   // Slot phase and next anode/segment drive from the current counter state
   always_comb begin
      // BLANK_CYCLES >= DIVISOR keeps every tick in the blank window
      slot_state = (32'(tick_cnt_q) < BLANK_CYCLES) ? SLOT_BLANK : SLOT_DRIVE;
`ifdef SEG7_SCAN_DIM_EN
      // Outside the PWM on-window the drive phase behaves exactly like blank
      if (pwm_cnt_q > brightness) begin
         slot_state = SLOT_BLANK;
      end
`endif
      case (dig_q)
         2'd0:    digit_pat = frame_q[6:0];
         2'd1:    digit_pat = frame_q[13:7];
         2'd2:    digit_pat = frame_q[20:14];
         default: digit_pat = frame_q[27:21];
      endcase
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      if (slot_state == SLOT_DRIVE) begin
         // A blank digit still gets its anode; only the segments stay dark
         an_d  = ~(4'b0001 << dig_q);
         seg_d = ~digit_pat;
      end
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q   <= '0;
         dig_q        <= 2'd0;
         frame_q      <= 28'd0;
         an_q         <= 4'b1111;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frame_sync_q <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
         pwm_cnt_q    <= 4'd0;
`endif
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         dig_q        <= dig_d;
         frame_q      <= frame_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_sync_q <= frame_sync_d;
`ifdef SEG7_SCAN_DIM_EN
         pwm_cnt_q    <= pwm_cnt_d;
`endif
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIVISOR=8, BLANK_CYCLES=2.
// The stimulus process pushes the hand-derived expected output for every
// clock after reset release; a negedge monitor pops and compares.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [27:0] frame;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_sync;
`ifdef SEG7_SCAN_DIM_EN
   logic [3:0]  brightness;
`endif

   seg7_scan_driver #(.DIVISOR(8), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame      (frame),
`ifdef SEG7_SCAN_DIM_EN
      .brightness (brightness),
`endif
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_sync (frame_sync)
   );

   typedef struct {
      int       n;
      logic [3:0] an;
      logic [6:0] seg;
      logic       fs;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   // Expected active-low segment code per scan (row) and digit (column)
   logic [6:0] seg_tab [4][4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare every presented output sample against the scoreboard
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         vectors++;
         if (an !== mon_e.an || seg !== mon_e.seg || frame_sync !== mon_e.fs || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL cycle%0d: got an=%b seg=%h fs=%b dp=%b, want an=%b seg=%h fs=%b dp=1",
                     mon_e.n, an, seg, frame_sync, dp, mon_e.an, mon_e.seg, mon_e.fs);
         end
      end
   end

   // Push the expected sample for cycle n (sampled after the n-th edge since release)
   task automatic push_exp(input int n, input int scan_row);
      exp_t e;
      int   st, tick, d;
      st   = n - 1;
      tick = st % 8;
      d    = (st / 8) % 4;
      e.n  = n;
      e.fs = (n % 32 == 0) ? 1'b1 : 1'b0;
      if (tick < 2) begin
         e.an  = 4'b1111;
         e.seg = 7'h7F;
      end else begin
         case (d)
            0: e.an = 4'b1110;
            1: e.an = 4'b1101;
            2: e.an = 4'b1011;
            default: e.an = 4'b0111;
         endcase
         e.seg = seg_tab[scan_row][d];
      end
      sb.push_back(e);
   endtask

   task automatic check_direct(input string name, input logic [12:0] got, input logic [12:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   initial begin
      // Scan 0: frame_q still zero. Scan 1: {118,63,56,119}. Scan 2: zero frame.
      // Scan 3: {7F,00,06,5B}.
      seg_tab[0] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
      seg_tab[1] = '{7'h08, 7'h47, 7'h40, 7'h09};
      seg_tab[2] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
      seg_tab[3] = '{7'h24, 7'h79, 7'h7F, 7'h00};
`ifdef SEG7_SCAN_DIM_EN
      brightness = 4'd15;
`endif
      frame = {7'd118, 7'd63, 7'd56, 7'd119};
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_direct("reset_state", {an, seg, dp, frame_sync}, {4'b1111, 7'h7F, 1'b1, 1'b0});

      // Short run into the first drive slot, then asynchronous reset mid-drive
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk);
         push_exp(n, 0);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_direct("async_reset_mid_drive", {an, seg, dp, frame_sync}, {4'b1111, 7'h7F, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      check_direct("held_in_reset", {an, seg, dp, frame_sync}, {4'b1111, 7'h7F, 1'b1, 1'b0});

      // Four full scans after a clean release
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 128; n++) begin
         @(posedge clk);
         push_exp(n, (n - 1) / 32);
         if (n == 42) frame = 28'h0;                               // mid digit1 of scan 1
         if (n == 70) frame = {7'h7F, 7'h00, 7'h06, 7'h5B};        // during scan 2
      end

      // Bounded drain of the scoreboard
      repeat (3) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
